// File: rtl/cryptoram_arb_pkg.sv
// Shared types for the crypto RAM arbiter: clear-sequencer states,
// read-return tag layout and the owner encoding of the two masters.
package cryptoram_arb_pkg;

    // Clear sequencer states; IDLE is the all-zero encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_KICK   = 3'd2,
        ST_WAITHI = 3'd3,
        ST_WAITLO = 3'd4
    } clr_state_e;

    // One entry of the read-return pipe.
    typedef struct packed {
        logic vld;
        logic own;
    } rtag_t;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/cryptoram_arb_if.sv
// Master-side port bundle of the crypto RAM arbiter.
//
// Handshake: the master raises req with addr/rd/wr/wdat and holds all of
// them stable until it sees gnt=1 in the same cycle; gnt is a one-cycle
// acceptance. Read data comes back as a single-cycle rvalid pulse with
// rdat/rerr and cannot be back-pressured. rdat is zero whenever rvalid=0.
interface cryptoram_arb_if #(
    parameter int AW = 10,
    parameter int DW = 32
) ();
    logic            req;
    logic [AW-1:0]   addr;
    logic            rd;
    logic [DW/8-1:0] wr;
    logic [DW-1:0]   wdat;
    logic            gnt;
    logic            rvalid;
    logic [DW-1:0]   rdat;
    logic            rerr;

    modport master (
        output req, addr, rd, wr, wdat,
        input  gnt, rvalid, rdat, rerr
    );

    modport slave (
        input  req, addr, rd, wr, wdat,
        output gnt, rvalid, rdat, rerr
    );
endinterface

// File: rtl/cryptoram_rtag.sv
// Read-return tag pipe: a DEPTH-deep shift register of {vld, own} that
// lines up with the RAM read latency, plus an empty flag for clear drain.
module cryptoram_rtag
    import cryptoram_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic  clk,
    input  logic  reset,
    input  rtag_t tag_in,
    output rtag_t tag_out,
    output logic  empty
);

    rtag_t stage_q [DEPTH];
    rtag_t stage_d [DEPTH];

    // Next-stage values: new tag enters at the head, everything shifts by one.
    always_comb begin
        stage_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Pipe registers, cleared by reset so no stale return survives it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) begin
                stage_q[i] <= '0;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    // Empty when no stage holds an outstanding read.
    always_comb begin
        empty = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (stage_q[i].vld) begin
                empty = 1'b0;
            end
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/cryptoram_arb.sv
// Two-master round-robin arbiter and clear sequencer in front of the
// crypto RAM wrapper. Port A is the SCE datapath, port B the AHB/DMA side.
module cryptoram_arb
    import cryptoram_arb_pkg::*;
#(
    parameter int AW    = 10,
    parameter int DW    = 32,
    parameter int RDLAT = 1
) (
    input  logic            clk,
    input  logic            reset,
    cryptoram_arb_if.slave  a_if,
    cryptoram_arb_if.slave  b_if,
    input  logic            clr_req,
    output logic            clr_busy,
    output logic            clr_done,
    output logic            ramclr,
    output logic [AW-1:0]   ramaddr,
    output logic            ramen,
    output logic            ramrd,
    output logic [DW/8-1:0] ramwr,
    output logic [DW-1:0]   ramwdat,
    input  logic [DW-1:0]   ramrdat,
    input  logic            ramready,
    input  logic [1:0]      ramerror,
    input  logic            ramclren,
    output clr_state_e      dbg_state
);

    clr_state_e state_q, state_d;
    logic       last_q, last_d;
    logic       grant_ok, gnt_a, gnt_b, win;
    rtag_t      tag_in, tag_out;
    logic       pipe_empty;

    // Round-robin pick; a clear request in the same cycle takes priority
    // over any port, and an externally running clear stalls everyone.
    always_comb begin
        grant_ok = !reset && (state_q == ST_IDLE) && ramready && !ramclren && !clr_req;
        gnt_a    = grant_ok && a_if.req && (!b_if.req || (last_q == OWN_B));
        gnt_b    = grant_ok && b_if.req && !gnt_a;
        win      = gnt_b ? OWN_B : OWN_A;
        last_d   = (gnt_a || gnt_b) ? win : last_q;
    end

    // Drive the winner onto the RAM port; writes never also issue a read.
    always_comb begin
        ramen   = 1'b0;
        ramrd   = 1'b0;
        ramaddr = '0;
        ramwr   = '0;
        ramwdat = '0;
        if (gnt_a) begin
            ramen   = 1'b1;
            ramaddr = a_if.addr;
            ramwr   = a_if.wr;
            ramwdat = a_if.wdat;
            ramrd   = a_if.rd && (a_if.wr == '0);
        end else if (gnt_b) begin
            ramen   = 1'b1;
            ramaddr = b_if.addr;
            ramwr   = b_if.wr;
            ramwdat = b_if.wdat;
            ramrd   = b_if.rd && (b_if.wr == '0);
        end
    end

    assign tag_in.vld = ramrd;
    assign tag_in.own = win;

    cryptoram_rtag #(.DEPTH(RDLAT)) u_rtag (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out),
        .empty   (pipe_empty)
    );

    // Clear sequencer: drain outstanding reads, kick the wrapper, then
    // follow its clear-enable high and back low.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (clr_req)    state_d = ST_DRAIN;
            ST_DRAIN:  if (pipe_empty) state_d = ST_KICK;
            ST_KICK:                   state_d = ST_WAITHI;
            ST_WAITHI: if (ramclren)   state_d = ST_WAITLO;
            ST_WAITLO: if (!ramclren)  state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // State and round-robin pointer; after reset B counts as last granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= OWN_B;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    assign clr_busy  = (state_q != ST_IDLE);
    assign ramclr    = (state_q == ST_KICK);
    assign clr_done  = (state_q == ST_WAITLO) && !ramclren;
    assign dbg_state = state_q;

    assign a_if.gnt    = gnt_a;
    assign a_if.rvalid = tag_out.vld && (tag_out.own == OWN_A);
    assign a_if.rdat   = a_if.rvalid ? ramrdat : '0;
    assign a_if.rerr   = a_if.rvalid && (ramerror != 2'b00);

    assign b_if.gnt    = gnt_b;
    assign b_if.rvalid = tag_out.vld && (tag_out.own == OWN_B);
    assign b_if.rdat   = b_if.rvalid ? ramrdat : '0;
    assign b_if.rerr   = b_if.rvalid && (ramerror != 2'b00);

endmodule

// File: doc/cryptoram_arb.md
Name: cryptoram_arb

Overview:
Two-master arbiter and sequencer directly upstream of the crypto RAM wrapper. It drives the wrapper's single port (ramaddr/ramen/ramrd/ramwr/ramwdat, plus the ramclr pulse) and consumes ramrdat/ramready/ramerror/ramclren. Masters are port A (SCE engine datapath) and port B (AHB/DMA access). It provides round-robin grants, routes read returns to the owning master, and sequences RAM clears safely around outstanding reads.

Parameters:
AW, 10, RAM word address width
DW, 32, RAM data width; byte-enable width is DW/8
RDLAT, 1, cycles from accepted read to valid ramrdat (legal values 1..2)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
a_req  in  1  port A request; held until a_gnt
a_addr  in  AW  port A word address
a_rd  in  1  port A read
a_wr  in  DW/8  port A byte write enables
a_wdat  in  DW  port A write data
a_gnt  out  1  port A request accepted this cycle
a_rvalid  out  1  port A read data valid
a_rdat  out  DW  port A read data
a_rerr  out  1  port A read returned a RAM error
b_*  —  —  identical set for port B (b_req, b_addr, b_rd, b_wr, b_wdat, b_gnt, b_rvalid, b_rdat, b_rerr)
clr_req  in  1  pulse: request a full RAM clear
clr_busy  out  1  clear pending or in progress
clr_done  out  1  one-cycle pulse when clear finishes
ramclr  out  1  to wrapper: clear start pulse
ramaddr  out  AW  to wrapper
ramen  out  1  to wrapper
ramrd  out  1  to wrapper
ramwr  out  DW/8  to wrapper
ramwdat  out  DW  to wrapper
ramrdat  in  DW  from wrapper
ramready  in  1  from wrapper
ramerror  in  2  from wrapper (parity, verify)
ramclren  in  1  from wrapper: clear engine active

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high; all registers are updated only on clk edges.
- Reset values: FSM=IDLE, last-grant pointer=B (so A wins the first tie), tag pipe empty. Every output is 0.
- Grants are combinational within a cycle. Grants are given only when FSM=IDLE, ramready=1 and ramclren=0. At most one gnt per cycle.
- Arbitration: with a single requester, that requester is granted. With both requesting, the port other than the last-granted one wins. The pointer updates on every grant.
- A granted cycle drives the winner's addr, rd, wr and wdat onto the ram* outputs with ramen=1. When no grant is given, ramen, ramrd, ramwr, ramaddr and ramwdat are all 0.
- Read/write decode: a request is a write if |wr≠0. ramrd is forced to 0 on writes, even when rd=1. A request with rd=0 and wr=0 is granted as a no-op, with ramen=1 and no return.
- Read return: a tag pipe RDLAT deep carries {valid, owner}.
  - At the tail, the owner's rvalid pulses for 1 cycle with rdat=ramrdat and rerr=|ramerror.
  - The non-owner's rdat is 0.
  - Back-to-back reads are allowed, giving one return per cycle.
- Clear FSM:
  - IDLE: clr_req → DRAIN.
  - DRAIN: no grants; when the tag pipe is empty → KICK.
  - KICK: ramclr=1 for exactly 1 cycle → WAITHI.
  - WAITHI: when ramclren=1 → WAITLO.
  - WAITLO: when ramclren=0 → IDLE, with clr_done=1 that cycle.
  - clr_busy=1 in every state except IDLE.
- clr_req while not in IDLE is ignored. clr_req in the same cycle as a port request: the clear wins, no grant is given, and the FSM enters DRAIN.
- ramclren rising while in IDLE (clear started externally): grants stall until ramclren falls. No clr_done is produced.
- ramready=0: no grant is given. Pending requests stay held by their masters.
- Reset mid-clear: the FSM returns to IDLE. The wrapper clear continues independently; grants still stall on ramclren.

Decomposition:
- Shared package cryptoram_arb_pkg holds:
  - the clear-FSM state enum (IDLE, DRAIN, KICK, WAITHI, WAITLO);
  - the tag struct {logic vld; logic own;};
  - the owner constants OWN_A=0 and OWN_B=1.
- One sub-module: cryptoram_rtag, a parameterised RDLAT-deep shift pipe with an empty flag.

Test Plan:
- Test 1 (A only):
  - Stimulus: A writes addr 0x005, data 0xDEADBEEF, wr=4'hF; one cycle later A reads 0x005.
  - Response: a_gnt is given both cycles. a_rvalid fires RDLAT cycles after the read grant with a_rdat=0xDEADBEEF. b_rvalid stays 0.
- Test 2 (contention):
  - Stimulus: A and B both hold read requests for 4 cycles.
  - Response: grants go A,B,A,B. Returns are routed to the matching owner in the same order.
- Test 3 (clear with a read in flight):
  - Stimulus: A read is granted at cycle t; clr_req at t+1.
  - Response: a_rvalid is still delivered. ramclr pulses once after the pipe empties. No grants occur until clr_done. clr_busy is high from t+2 until clr_done.
- Test 4 (ramready stall):
  - Stimulus: ramready held at 0 for 3 cycles while B requests.
  - Response: b_gnt=0 for those 3 cycles, then b_gnt=1 on the first cycle with ramready=1.
- Test 5 (error propagation):
  - Stimulus: ramerror=2'b01 on the return cycle of a B read.
  - Response: b_rerr=1 and b_rvalid=1 in the same cycle. a_rerr=0.
- Test 6 (reset during WAITHI):
  - Stimulus: assert reset for 1 cycle while in WAITHI.
  - Response: all outputs are 0 and the FSM is IDLE. Grants resume only after ramclren=0.
